dac_segment_switch: RTL and testbench

DAC_SEGMENT_SWITCH -- requirements
Module: dac_segment_switch

---
 rtl/dac_seg_pkg.sv | 17 +
 rtl/dac_therm_decoder.sv | 24 ++
 rtl/dac_segment_switch.sv | 191 +++++++++++++++++++
 tb/tb_dac_segment_switch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dac_seg_pkg.sv
// Shared constants and FSM state encoding for the segmented current-steering DAC switch block.
package dac_seg_pkg;

    localparam int NUM_THERM = 17;
    localparam int NUM_BIN   = 6;
    localparam int CODE_W    = 11;
    localparam int CODE_MAX  = 1151;
    localparam int THERM_W   = 5;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } dac_state_e;

endpackage

// File: rtl/dac_therm_decoder.sv
// Maps a thermometer unit count and a rotation pointer to a 17-bit cell selection mask.
// Cell i is selected when its distance from the pointer (mod 17) is below the unit count.
module dac_therm_decoder
    import dac_seg_pkg::*;
(
    input  logic [THERM_W-1:0]   i_t,
    input  logic [THERM_W-1:0]   i_ptr,
    output logic [NUM_THERM-1:0] o_mask
);

    // Rotating thermometer decode: select t consecutive cells starting at ptr, wrapping at 17.
    always_comb begin
        o_mask = '0;
        for (int i = 0; i < NUM_THERM; i++) begin
            int v_off;
            v_off = i + NUM_THERM - int'(i_ptr);
            if (v_off >= NUM_THERM) begin
                v_off = v_off - NUM_THERM;
            end
            o_mask[i] = (v_off < int'(i_t));
        end
    end

endmodule

// File: rtl/dac_segment_switch.sv
// Segmented current-steering DAC switch controller: bias power sequencing FSM,
// code handshake with clamping, thermometer/binary switch registers and the
// behavioural differential current sum.
// Optional feature: define DAC_SEG_DWA_EN to rotate thermometer cell selection
// (data-weighted averaging); without it cells 0..t-1 are always used.
module dac_segment_switch
    import dac_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic              red_sel,
    input  real               iin_them [NUM_THERM],
    input  real               iin_binary [NUM_BIN],
    input  real               iin_binary_0_red,
    output real               iout_p,
    output real               iout_n,
    output logic              pdb_out,
    output logic              active,
    output logic              err_clamp
);

    dac_state_e              r_state;
    dac_state_e              w_state_nxt;
    logic [7:0]              r_settle_cnt;
    logic                    w_settle_done;
    logic [NUM_THERM-1:0]    r_therm_sw;
    logic [NUM_BIN-1:0]      r_bin_sw;
    logic [CODE_W-1:0]       w_code_sat;
    logic [THERM_W-1:0]      w_t;
    logic [NUM_BIN-1:0]      w_b;
    logic                    w_accept;
    logic                    w_enter_drain;
    logic [THERM_W-1:0]      w_ptr;
    logic [NUM_THERM-1:0]    w_mask;
    real                     w_sum_p;
    real                     w_sum_n;
    real                     w_bin_cur;

    // Saturate an incoming code to the largest representable full-scale value.
    function automatic logic [CODE_W-1:0] sat_code(input logic [CODE_W-1:0] c);
        if (c > CODE_W'(CODE_MAX)) begin
            return CODE_W'(CODE_MAX);
        end
        return c;
    endfunction

    assign w_code_sat    = sat_code(code);
    assign w_t           = w_code_sat[CODE_W-1:NUM_BIN];
    assign w_b           = w_code_sat[NUM_BIN-1:0];
    assign w_accept      = code_valid & code_ready;
    assign w_enter_drain = (w_state_nxt == ST_DRAIN) && (r_state != ST_DRAIN);
    assign w_settle_done = (r_settle_cnt == 8'(SETTLE_CYCLES - 1));

    assign code_ready = (r_state == ST_ACTIVE);
    assign active     = (r_state == ST_ACTIVE);
    assign pdb_out    = (r_state != ST_OFF);

`ifdef DAC_SEG_DWA_EN
    logic [THERM_W-1:0] r_ptr;
    logic [THERM_W:0]   w_ptr_sum;
    logic [THERM_W-1:0] w_ptr_nxt;

    assign w_ptr_sum = {1'b0, r_ptr} + {1'b0, w_t};
    assign w_ptr_nxt = (w_ptr_sum >= (THERM_W+1)'(NUM_THERM))
                     ? THERM_W'(w_ptr_sum - (THERM_W+1)'(NUM_THERM))
                     : THERM_W'(w_ptr_sum);
    assign w_ptr     = r_ptr;

    // Rotation pointer advances by the accepted unit count on every acceptance.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    assign w_ptr = '0;
`endif

    dac_therm_decoder u_therm_dec (
        .i_t    (w_t),
        .i_ptr  (w_ptr),
        .o_mask (w_mask)
    );

    // FSM state register and settle counter.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state      <= ST_OFF;
            r_settle_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + 8'd1;
            end else begin
                r_settle_cnt <= '0;
            end
        end
    end

    // Next-state logic: power up through a bias settle window, drain for one cycle on power down.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF:    if (en) w_state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (!en) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_settle_done) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: if (!en) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  w_state_nxt = ST_OFF;
            default:   w_state_nxt = ST_OFF;
        endcase
    end

    // Switch registers: load on acceptance, clear when entering DRAIN so the next power-up starts at zero.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_therm_sw <= '0;
            r_bin_sw   <= '0;
        end else if (w_enter_drain) begin
            r_therm_sw <= '0;
            r_bin_sw   <= '0;
        end else if (w_accept) begin
            r_therm_sw <= w_mask;
            r_bin_sw   <= w_b;
        end
    end

    // Sticky clamp flag, set whenever an out-of-range code is accepted.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            err_clamp <= 1'b0;
        end else if (w_accept && (code > CODE_W'(CODE_MAX))) begin
            err_clamp <= 1'b1;
        end
    end

    // Steer each cell current to the positive or negative output; gated by power state.
    always_comb begin
        w_sum_p   = 0.0;
        w_sum_n   = 0.0;
        w_bin_cur = 0.0;
        iout_p    = 0.0;
        iout_n    = 0.0;
        for (int i = 0; i < NUM_THERM; i++) begin
            if (r_therm_sw[i]) begin
                w_sum_p = w_sum_p + iin_them[i];
            end else begin
                w_sum_n = w_sum_n + iin_them[i];
            end
        end
        for (int k = 0; k < NUM_BIN; k++) begin
            if ((k == 0) && red_sel) begin
                w_bin_cur = iin_binary_0_red;
            end else begin
                w_bin_cur = iin_binary[k];
            end
            if (r_bin_sw[k]) begin
                w_sum_p = w_sum_p + w_bin_cur;
            end else begin
                w_sum_n = w_sum_n + w_bin_cur;
            end
        end
        case (r_state)
            ST_OFF: begin
                iout_p = 0.0;
                iout_n = 0.0;
            end
            ST_DRAIN: begin
                iout_p = 0.0;
                iout_n = w_sum_p + w_sum_n;
            end
            default: begin
                iout_p = w_sum_p;
                iout_n = w_sum_n;
            end
        endcase
    end

endmodule

// File: tb/tb_dac_segment_switch.sv
// Directed self-checking bench for dac_segment_switch (SETTLE_CYCLES = 4).
module tb_dac_segment_switch;

    localparam real T_FULL = 3.596875e-3;

    logic        clk;
    logic        rstb;
    logic        en;
    logic [10:0] code;
    logic        code_valid;
    logic        code_ready;
    logic        red_sel;
    real         iin_them [17];
    real         iin_binary [6];
    real         iin_binary_0_red;
    real         iout_p;
    real         iout_n;
    logic        pdb_out;
    logic        active;
    logic        err_clamp;

    int n_cmp  = 0;
    int n_fail = 0;

    dac_segment_switch #(.SETTLE_CYCLES(4)) dut (
        .clk              (clk),
        .rstb             (rstb),
        .en               (en),
        .code             (code),
        .code_valid       (code_valid),
        .code_ready       (code_ready),
        .red_sel          (red_sel),
        .iin_them         (iin_them),
        .iin_binary       (iin_binary),
        .iin_binary_0_red (iin_binary_0_red),
        .iout_p           (iout_p),
        .iout_n           (iout_n),
        .pdb_out          (pdb_out),
        .active           (active),
        .err_clamp        (err_clamp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_real(input string tag, input real obs, input real exp);
        n_cmp++;
        assert ((obs - exp) < 1.0e-12 && (exp - obs) < 1.0e-12) else begin
            n_fail++;
            $error("FAIL %s: observed %g expected %g", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [10:0] c);
        code       = c;
        code_valid = 1'b1;
        step();
        code_valid = 1'b0;
    endtask

    task automatic wait_active(input string tag);
        for (int i = 0; i < 20; i++) begin
            step();
            if (active === 1'b1) break;
        end
        check_bit(tag, active, 1'b1);
    endtask

    initial begin
        rstb             = 1'b0;
        en               = 1'b0;
        code             = '0;
        code_valid       = 1'b0;
        red_sel          = 1'b0;
        iin_binary_0_red = 3.125e-6;
        for (int i = 0; i < 17; i++) iin_them[i] = 200.0e-6;
        for (int k = 0; k < 6; k++) iin_binary[k] = 3.125e-6 * real'(1 << k);

        // reset state
        #12;
        check_bit("rst_pdb", pdb_out, 1'b0);
        check_bit("rst_ready", code_ready, 1'b0);
        check_bit("rst_active", active, 1'b0);
        check_bit("rst_err", err_clamp, 1'b0);
        check_real("rst_iout_p", iout_p, 0.0);
        check_real("rst_iout_n", iout_n, 0.0);
        @(posedge clk);
        #1;
        rstb = 1'b1;

        // power-up sequence with 4 settle cycles
        en = 1'b1;
        step();
        check_bit("settle_pdb", pdb_out, 1'b1);
        check_bit("settle_active0", active, 1'b0);
        check_bit("settle_ready0", code_ready, 1'b0);
        check_real("settle_iout_p", iout_p, 0.0);
        check_real("settle_iout_n", iout_n, T_FULL);
        for (int i = 1; i < 4; i++) begin
            step();
            check_bit("settle_active", active, 1'b0);
            check_bit("settle_ready", code_ready, 1'b0);
        end
        step();
        check_bit("act_active", active, 1'b1);
        check_bit("act_ready", code_ready, 1'b1);

        // full scale
        accept(11'd1151);
        check_real("fs_iout_p", iout_p, T_FULL);
        check_real("fs_iout_n", iout_n, 0.0);
        check_bit("fs_err", err_clamp, 1'b0);

        // single LSB, then redundant LSB selection
        accept(11'd1);
        check_real("lsb_iout_p", iout_p, 3.125e-6);
        iin_binary[0]    = 3.0e-6;
        iin_binary_0_red = 3.25e-6;
        red_sel          = 1'b1;
        #1;
        check_real("red_comb_on", iout_p, 3.25e-6);
        red_sel = 1'b0;
        #1;
        check_real("red_comb_off", iout_p, 3.0e-6);
        red_sel = 1'b1;
        accept(11'd1);
        check_real("red_code1", iout_p, 3.25e-6);
        red_sel       = 1'b0;
        iin_binary[0] = 3.125e-6;

        // no acceptance -> hold
        code = 11'd500;
        step();
        check_real("hold_iout_p", iout_p, 3.125e-6);

        // clamp
        accept(11'd2000);
        check_real("clamp_iout_p", iout_p, T_FULL);
        check_bit("clamp_err", err_clamp, 1'b1);

        // code 100: t=1, b=36
        accept(11'd100);
        check_real("c100_iout_p", iout_p, 312.5e-6);
        check_real("c100_iout_n", iout_n, T_FULL - 312.5e-6);

        // power down through DRAIN
        en = 1'b0;
        step();
        check_bit("drain_ready", code_ready, 1'b0);
        check_bit("drain_active", active, 1'b0);
        check_bit("drain_pdb", pdb_out, 1'b1);
        check_real("drain_iout_p", iout_p, 0.0);
        check_real("drain_iout_n", iout_n, T_FULL);
        step();
        check_bit("off_pdb", pdb_out, 1'b0);
        check_real("off_iout_p", iout_p, 0.0);
        check_real("off_iout_n", iout_n, 0.0);
        check_bit("off_err_sticky", err_clamp, 1'b1);

        // re-enable: starts from code 0, clamp flag still sticky
        en = 1'b1;
        wait_active("reup_active");
        check_real("reup_iout_p", iout_p, 0.0);
        check_real("reup_iout_n", iout_n, T_FULL);
        check_bit("reup_err", err_clamp, 1'b1);

        // asynchronous reset mid-ACTIVE
        en = 1'b0;
        @(negedge clk);
        rstb = 1'b0;
        #1;
        check_bit("arst_pdb", pdb_out, 1'b0);
        check_bit("arst_active", active, 1'b0);
        check_bit("arst_err", err_clamp, 1'b0);
        check_real("arst_iout_p", iout_p, 0.0);
        check_real("arst_iout_n", iout_n, 0.0);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        step();
        check_bit("arst_rel_pdb", pdb_out, 1'b0);

        // en dropped during SETTLE -> DRAIN -> OFF
        en = 1'b1;
        step();
        check_bit("abort_settle_pdb", pdb_out, 1'b1);
        en = 1'b0;
        step();
        check_bit("abort_drain_pdb", pdb_out, 1'b1);
        check_bit("abort_drain_ready", code_ready, 1'b0);
        check_real("abort_drain_iout_n", iout_n, T_FULL);
        step();
        check_bit("abort_off_pdb", pdb_out, 1'b0);

        // thermometer cell selection with distinguishable cell currents
        for (int i = 0; i < 17; i++) iin_them[i] = real'(i + 1) * 1.0e-6;
        en = 1'b1;
        wait_active("dwa_active");
        accept(11'd640);
        check_real("therm_640_a", iout_p, 55.0e-6);
        accept(11'd640);
`ifdef DAC_SEG_DWA_EN
        check_real("therm_640_b", iout_p, 104.0e-6);
`else
        check_real("therm_640_b", iout_p, 55.0e-6);
`endif
        accept(11'd64);
`ifdef DAC_SEG_DWA_EN
        check_real("therm_ptr", iout_p, 4.0e-6);
`else
        check_real("therm_ptr", iout_p, 1.0e-6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
